// File: rtl/mac_tx_arbiter.sv
// N-channel AXI-Stream transmit arbiter: round-robin frame-level grant, one output register stage,
// oversize frames truncated then drained. Define MAC_TX_ARB_STRICT_PRIORITY_EN for lowest-index-wins arbitration.
module mac_tx_arbiter #(
  parameter int N_CHANNELS = 4,
  parameter int MAX_BEATS  = 192
) (
  input  logic                                             i_xver_txc,
  input  logic                                             i_tx_reset,
  input  logic [64*N_CHANNELS-1:0]                         s_axis_tdata,
  input  logic [8*N_CHANNELS-1:0]                          s_axis_tkeep,
  input  logic [N_CHANNELS-1:0]                            s_axis_tvalid,
  input  logic [N_CHANNELS-1:0]                            s_axis_tlast,
  output logic [N_CHANNELS-1:0]                            s_axis_tready,
  output logic [63:0]                                      m00_axis_tdata,
  output logic [7:0]                                       m00_axis_tkeep,
  output logic                                             m00_axis_tvalid,
  output logic                                             m00_axis_tlast,
  input  logic                                             m00_axis_tready,
  output logic [((N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1)-1:0] o_active_channel,
  output logic                                             o_busy,
  output logic                                             o_oversize
);

  localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, FORWARD, DRAIN} state_t;

  state_t           state_reg;
  logic [CH_W-1:0]  sel_reg;
  logic [CNT_W-1:0] beat_cnt_reg;
  logic [63:0]      out_data_reg;
  logic [7:0]       out_keep_reg;
  logic             out_valid_reg;
  logic             out_last_reg;
  logic             oversize_reg;

  logic [63:0] ch_data [N_CHANNELS];
  logic [7:0]  ch_keep [N_CHANNELS];

  generate
    for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_split
      assign ch_data[gi] = s_axis_tdata[64*gi +: 64];
      assign ch_keep[gi] = s_axis_tkeep[8*gi +: 8];
    end
  endgenerate

  logic [63:0] sel_data;
  logic [7:0]  sel_keep;
  logic        sel_valid;
  logic        sel_last;
  logic        out_ready;
  logic        accept;
  logic        discard;
  logic        at_limit;

  assign sel_data  = ch_data[sel_reg];
  assign sel_keep  = ch_keep[sel_reg];
  assign sel_valid = s_axis_tvalid[sel_reg];
  assign sel_last  = s_axis_tlast[sel_reg];

  // The output register can take a beat when it is empty or being emptied this cycle.
  assign out_ready = !out_valid_reg || m00_axis_tready;
  assign accept    = (state_reg == FORWARD) && sel_valid && out_ready;
  assign discard   = (state_reg == DRAIN) && sel_valid;
  assign at_limit  = (beat_cnt_reg == CNT_W'(MAX_BEATS - 1));

  always_comb begin
    s_axis_tready = '0;
    case (state_reg)
      FORWARD: s_axis_tready[sel_reg] = out_ready;
      DRAIN:   s_axis_tready[sel_reg] = 1'b1;
      default: s_axis_tready = '0;
    endcase
  end

  logic            win_found;
  logic [CH_W-1:0] winner;

`ifdef MAC_TX_ARB_STRICT_PRIORITY_EN
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i]) begin
        win_found = 1'b1;
        winner    = CH_W'(i);
      end
    end
  end
`else
  logic [CH_W-1:0] last_grant_reg;

  function automatic logic [CH_W-1:0] wrap_idx(input int v);
    if (v >= N_CHANNELS) return CH_W'(v - N_CHANNELS);
    return CH_W'(v);
  endfunction

  // Scan from farthest to nearest so the channel right after last_grant wins.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    for (int k = N_CHANNELS; k >= 1; k--) begin
      if (s_axis_tvalid[wrap_idx(int'(last_grant_reg) + k)]) begin
        win_found = 1'b1;
        winner    = wrap_idx(int'(last_grant_reg) + k);
      end
    end
  end
`endif

  always_ff @(posedge i_xver_txc) begin
    if (i_tx_reset) begin
      state_reg      <= IDLE;
      sel_reg        <= '0;
      beat_cnt_reg   <= '0;
      out_data_reg   <= '0;
      out_keep_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      oversize_reg   <= 1'b0;
`ifndef MAC_TX_ARB_STRICT_PRIORITY_EN
      last_grant_reg <= CH_W'(N_CHANNELS - 1);
`endif
    end else begin
      oversize_reg <= 1'b0;

      if (accept) begin
        out_data_reg  <= sel_data;
        out_keep_reg  <= sel_keep;
        out_valid_reg <= 1'b1;
        out_last_reg  <= sel_last || at_limit;
      end else if (m00_axis_tready) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (win_found) begin
            sel_reg        <= winner;
`ifndef MAC_TX_ARB_STRICT_PRIORITY_EN
            last_grant_reg <= winner;
`endif
            beat_cnt_reg   <= '0;
            state_reg      <= FORWARD;
          end
        end
        FORWARD: begin
          if (accept) begin
            if (beat_cnt_reg != CNT_W'(MAX_BEATS))
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (sel_last) begin
              state_reg <= IDLE;
            end else if (at_limit) begin
              oversize_reg <= 1'b1;
              state_reg    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (discard && sel_last)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m00_axis_tdata   = out_data_reg;
  assign m00_axis_tkeep   = out_keep_reg;
  assign m00_axis_tvalid  = out_valid_reg;
  assign m00_axis_tlast   = out_last_reg;
  assign o_active_channel = sel_reg;
  assign o_busy           = (state_reg != IDLE);
  assign o_oversize       = oversize_reg;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Self-checking bench for mac_tx_arbiter (N=4, MAX_BEATS=4): frame-level reference model,
// directed vector table, hand sequences and randomized traffic with backpressure.
module tb_mac_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int ch;
    int len;
    int exp_beats;
    int exp_over;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [64*N-1:0] s_data = '0;
  logic [8*N-1:0]  s_keep = '0;
  logic [N-1:0]    s_valid = '0;
  logic [N-1:0]    s_last = '0;
  logic [N-1:0]    s_ready;
  logic [63:0]     m_data;
  logic [7:0]      m_keep;
  logic            m_valid;
  logic            m_last;
  logic            m_ready = 1'b0;
  logic [1:0]      active;
  logic            busy;
  logic            oversize;

  mac_tx_arbiter #(.N_CHANNELS(N), .MAX_BEATS(MB)) dut (
    .i_xver_txc       (clk),
    .i_tx_reset       (rst),
    .s_axis_tdata     (s_data),
    .s_axis_tkeep     (s_keep),
    .s_axis_tvalid    (s_valid),
    .s_axis_tlast     (s_last),
    .s_axis_tready    (s_ready),
    .m00_axis_tdata   (m_data),
    .m00_axis_tkeep   (m_keep),
    .m00_axis_tvalid  (m_valid),
    .m00_axis_tlast   (m_last),
    .m00_axis_tready  (m_ready),
    .o_active_channel (active),
    .o_busy           (busy),
    .o_oversize       (oversize)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t src_q [N][$];
  beat_t exp_q [$];
  int    valid_pct [N];
  int    ready_pct = 100;
  int    cur_ch = -1;
  int    beat_no = 0;
  bit    drain_m = 0;
  bit    exp_over_next = 0;
  bit    arb_pending = 0;
  int    last_grant_m = N - 1;
  int    exp_winner = 0;
  int    cyc = 0;
  int    out_beats = 0;
  int    over_cnt = 0;
  int    ofr_beats = 0;
  int    grants [$];
  int    out_t [$];
  logic [63:0] p_data;
  logic [7:0]  p_keep;
  logic        p_last;
  bit          p_hold = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Which channel the arbitration rules say should win, given the valids seen in an idle cycle.
  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef MAC_TX_ARB_STRICT_PRIORITY_EN
    for (int i = 0; i < N; i++)
      if (v[i]) return i + 0 * last;
`else
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  // Frame-level model: first MB beats pass through, beat MB of a longer frame gets tlast, the rest vanish.
  task automatic model_accept(input int ch, input beat_t b);
    beat_t o;
    if (cur_ch < 0) begin
      chk("frame_grant", 64'(ch), 64'(last_grant_m));
      cur_ch  = ch;
      beat_no = 0;
      drain_m = 0;
    end else begin
      chk("no_interleave", 64'(ch), 64'(cur_ch));
    end
    beat_no++;
    if (!drain_m) begin
      o = b;
      if (beat_no == MB && !b.last) begin
        o.last        = 1'b1;
        exp_over_next = 1;
        drain_m       = 1;
      end
      exp_q.push_back(o);
    end
    if (b.last) begin
      cur_ch  = -1;
      drain_m = 0;
    end
  endtask

  task automatic cycle();
    beat_t       b;
    logic [N-1:0] allowed;
    @(negedge clk);
    cyc++;
    chk("oversize", 64'(oversize), 64'(exp_over_next));
    exp_over_next = 0;
    if (oversize) over_cnt++;
    if (arb_pending) begin
      chk("grant_ch", 64'(active), 64'(exp_winner));
      chk("grant_busy", 64'(busy), 64'(1));
      grants.push_back(int'(active));
      arb_pending = 0;
    end
    if (p_hold) begin
      chk("hold_valid", 64'(m_valid), 64'(1));
      chk("hold_data", m_data, p_data);
      chk("hold_keep", 64'(m_keep), 64'(p_keep));
      chk("hold_last", 64'(m_last), 64'(p_last));
    end

    m_ready = ($urandom_range(99) < ready_pct);
    for (int c = 0; c < N; c++) begin
      if (src_q[c].size() != 0 && $urandom_range(99) < valid_pct[c]) begin
        s_valid[c]          = 1'b1;
        s_data[64*c +: 64]  = src_q[c][0].data;
        s_keep[8*c +: 8]    = src_q[c][0].keep;
        s_last[c]           = src_q[c][0].last;
      end else begin
        s_valid[c]          = 1'b0;
        s_data[64*c +: 64]  = {$urandom(), $urandom()};
        s_keep[8*c +: 8]    = 8'($urandom());
        s_last[c]           = 1'($urandom_range(1));
      end
    end
    #1;

    if (!busy && s_valid != '0) begin
      exp_winner   = pick(s_valid, last_grant_m);
      last_grant_m = exp_winner;
      arb_pending  = 1;
    end

    allowed = busy ? (N'(1) << active) : '0;
    chk("ready_owner", 64'(s_ready & ~allowed), 64'(0));
    if (m_valid && !m_ready && !drain_m)
      chk("ready_backpressure", 64'(s_ready), 64'(0));

    if (m_valid && m_ready) begin
      out_t.push_back(cyc);
      out_beats++;
      ofr_beats++;
      chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        chk("out_data", m_data, b.data);
        chk("out_keep", 64'(m_keep), 64'(b.keep));
        chk("out_last", 64'(m_last), 64'(b.last));
      end
      if (m_last) begin
        $display("out frame: %0d beats ending cycle %0d", ofr_beats, cyc);
        ofr_beats = 0;
      end
    end

    for (int c = 0; c < N; c++) begin
      if (s_valid[c] && s_ready[c]) begin
        b = src_q[c].pop_front();
        model_accept(c, b);
      end
    end

    p_hold = m_valid && !m_ready;
    p_data = m_data;
    p_keep = m_keep;
    p_last = m_last;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m_ready = 1'b1;
      s_valid = '1;
      s_keep  = '1;
      s_last  = N'($urandom());
      for (int c = 0; c < N; c++) s_data[64*c +: 64] = {$urandom(), $urandom()};
    end
    @(negedge clk);
    chk("rst_tdata", m_data, 64'(0));
    chk("rst_tkeep", 64'(m_keep), 64'(0));
    chk("rst_tvalid", 64'(m_valid), 64'(0));
    chk("rst_tlast", 64'(m_last), 64'(0));
    chk("rst_tready", 64'(s_ready), 64'(0));
    chk("rst_active", 64'(active), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_oversize", 64'(oversize), 64'(0));
    for (int c = 0; c < N; c++) begin
      src_q[c].delete();
      valid_pct[c] = 100;
    end
    exp_q.delete();
    grants.delete();
    out_t.delete();
    cur_ch = -1; drain_m = 0; exp_over_next = 0; arb_pending = 0; p_hold = 0;
    last_grant_m = N - 1; out_beats = 0; over_cnt = 0; ofr_beats = 0; ready_pct = 100;
    s_valid = '0;
    rst     = 1'b0;
  endtask

  task automatic push_frame(input int ch, input int len, input logic [63:0] base);
    beat_t b;
    for (int i = 1; i <= len; i++) begin
      b.data = base + 64'(i);
      b.keep = (i == len) ? 8'($urandom_range(1, 255)) : 8'hFF;
      b.last = (i == len);
      src_q[ch].push_back(b);
    end
  endtask

  task automatic run_until_idle(input int budget);
    bit done = 0;
    int n = 0;
    while (!done && n < budget) begin
      cycle();
      n++;
      done = (exp_q.size() == 0) && !busy && !m_valid;
      for (int c = 0; c < N; c++) if (src_q[c].size() != 0) done = 0;
    end
    chk("idle_within_budget", 64'(done), 64'(1));
  endtask

  vec_t vecs [7];
  int   rr_exp [4];
  int   two_exp [6];

  initial begin
    vecs[0] = '{ch: 1, len: 6, exp_beats: 4, exp_over: 1};
    vecs[1] = '{ch: 2, len: 4, exp_beats: 4, exp_over: 0};
    vecs[2] = '{ch: 0, len: 1, exp_beats: 1, exp_over: 0};
    vecs[3] = '{ch: 3, len: 5, exp_beats: 4, exp_over: 1};
    vecs[4] = '{ch: 1, len: 3, exp_beats: 3, exp_over: 0};
    vecs[5] = '{ch: 0, len: 7, exp_beats: 4, exp_over: 1};
    vecs[6] = '{ch: 2, len: 2, exp_beats: 2, exp_over: 0};
    rr_exp  = '{0, 2, 0, 2};
`ifdef MAC_TX_ARB_STRICT_PRIORITY_EN
    two_exp = '{0, 0, 0, 3, 3, 3};
`else
    two_exp = '{0, 3, 0, 3, 0, 3};
`endif

    // Reset values, then all four channels valid: channel 0 is granted first.
    do_reset();
    for (int c = 0; c < N; c++) push_frame(c, 1, 64'(c) << 32);
    run_until_idle(60);
    chk("first_grant_count", 64'(grants.size()), 64'(4));
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk("first_grant_order", 64'(grants[i]), 64'(i));

    // Round-robin between channels 0 and 2 with 3-beat frames.
    do_reset();
    for (int f = 0; f < 2; f++) begin
      push_frame(0, 3, 64'h0A00 + 64'(f * 16));
      push_frame(2, 3, 64'h0C00 + 64'(f * 16));
    end
    run_until_idle(80);
    chk("rr_grant_count", 64'(grants.size()), 64'(4));
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk("rr_grant_order", 64'(grants[i]), 64'(rr_exp[i]));
    chk("rr_out_beats", 64'(out_t.size()), 64'(12));
    for (int i = 0; i + 1 < out_t.size(); i++)
      chk("rr_spacing", 64'(out_t[i+1] - out_t[i]), 64'((i % 3 == 2) ? 2 : 1));

    // Vector table: frame length against truncation limit.
    do_reset();
    for (int v = 0; v < 7; v++) begin
      out_beats = 0;
      over_cnt  = 0;
      push_frame(vecs[v].ch, vecs[v].len, 64'(v) << 40);
      run_until_idle(60);
      chk("vec_out_beats", 64'(out_beats), 64'(vecs[v].exp_beats));
      chk("vec_oversize_pulses", 64'(over_cnt), 64'(vecs[v].exp_over));
    end

    // Backpressure: MAC stalls for 5 cycles mid-frame.
    do_reset();
    push_frame(3, 4, 64'hB000);
    cycle(); cycle(); cycle();
    ready_pct = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_tvalid", 64'(m_valid), 64'(1));
      chk("bp_sready", 64'(s_ready), 64'(0));
    end
    ready_pct = 100;
    run_until_idle(40);
    chk("bp_out_beats", 64'(out_beats), 64'(4));

    // Randomized traffic; the last episode is cut by a reset mid-frame.
    for (int ep = 0; ep < 3; ep++) begin
      do_reset();
      for (int c = 0; c < N; c++) valid_pct[c] = $urandom_range(50, 100);
      ready_pct = $urandom_range(40, 90);
      for (int t = 0; t < 300; t++) begin
        if ($urandom_range(99) < 15) begin
          int c;
          c = $urandom_range(N - 1);
          if (src_q[c].size() < 12)
            push_frame(c, $urandom_range(1, 7), {8'(ep), 8'(c), 16'(t), 32'h0});
        end
        cycle();
      end
      if (ep != 2) begin
        for (int c = 0; c < N; c++) valid_pct[c] = 100;
        ready_pct = 100;
        run_until_idle(400);
      end
    end

    // Channels 0 and 3 both continuously offering frames.
    do_reset();
    for (int f = 0; f < 3; f++) begin
      push_frame(0, 2, 64'hD000 + 64'(f * 16));
      push_frame(3, 2, 64'hE000 + 64'(f * 16));
    end
    run_until_idle(100);
    chk("two_grant_count", 64'(grants.size()), 64'(6));
    for (int i = 0; i < grants.size() && i < 6; i++)
      chk("two_grant_order", 64'(grants[i]), 64'(two_exp[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Parametrised N-channel transmit ingress arbiter that sits in front of the MAC transmit AXI-Stream port in the `i_xver_txc` domain. It merges N independent 64-bit AXIS frame sources into one stream and switches channels only at frame boundaries, using round-robin arbitration. Each frame is forwarded through one output register stage. Frames longer than a configured maximum beat count are truncated and then drained, so one misbehaving source cannot hold the link.

## Interface
- N_CHANNELS, 4, number of input AXIS channels (1–16)
- MAX_BEATS, 192, maximum forwarded 64-bit beats per frame (≥2)
- i_xver_txc  in  1  transmit clock; sole clock of the block
- i_tx_reset  in  1  reset; synchronous, active-high
- s_axis_tdata  in  64*N_CHANNELS  channel k data occupies bits [64k+63:64k]
- s_axis_tkeep  in  8*N_CHANNELS  per-channel byte enables
- s_axis_tvalid  in  N_CHANNELS  per-channel valid
- s_axis_tlast  in  N_CHANNELS  per-channel end of frame
- s_axis_tready  out  N_CHANNELS  per-channel ready
- m00_axis_tdata  out  64  merged data to MAC
- m00_axis_tkeep  out  8  merged byte enables
- m00_axis_tvalid  out  1  merged valid
- m00_axis_tlast  out  1  merged end of frame
- m00_axis_tready  in  1  MAC ready; the MAC drops this during PCS gearbox pauses
- o_active_channel  out  max(1,$clog2(N_CHANNELS))  currently granted channel
- o_busy  out  1  high while the block is in FORWARD or DRAIN
- o_oversize  out  1  one-cycle pulse when a frame is truncated

## Operation
- The state machine has three states: IDLE, FORWARD and DRAIN.
- **IDLE**
  - All s_axis_tready outputs are 0.
  - If any s_axis_tvalid is high, a winner is picked. The search is round-robin and starts at last_grant+1, wrapping modulo N_CHANNELS.
  - On the cycle a winner is picked: latch sel and last_grant, clear the beat counter, and go to FORWARD on the next cycle.
- **FORWARD**
  - s_axis_tready[sel] = !m00_axis_tvalid || m00_axis_tready. All other ready bits are 0.
  - An accepted beat is loaded into the output register and the beat counter increments.
  - If the accepted beat has tlast: go to IDLE.
  - Otherwise, if the accepted beat is beat number MAX_BEATS: load it with m00_axis_tlast forced to 1 and tkeep unchanged, pulse o_oversize, and go to DRAIN.
- **DRAIN**
  - s_axis_tready[sel] = 1.
  - Accepted beats are discarded; nothing is emitted.
  - On acceptance of the input tlast beat, go to IDLE.
- **Output register**
  - m00_axis_tvalid clears when m00_axis_tready is high and no new beat is loaded.
  - The register holds all fields stable while tvalid=1 and tready=0.
- **Beat counter**
  - Width is $clog2(MAX_BEATS+1). It saturates and never wraps.
- **Boundary cases**
  - A frame of exactly MAX_BEATS beats whose last beat carries tlast is not oversize.
  - N_CHANNELS=1: always grant channel 0; arbitration still takes one IDLE cycle.
  - A winner's tvalid dropping between grant and FORWARD is legal; the block waits in FORWARD.
  - A channel's tvalid dropping mid-frame inserts a bubble on the output, not a channel switch.
  - The output register may still hold the final beat while the block is back in IDLE; it drains independently.
- **Reset**
  - Reset is honoured mid-frame. It aborts the current frame with no tlast emitted.
  - All outputs are 0, state is IDLE, and last_grant = N_CHANNELS-1, so channel 0 wins first.

## Timing
- Latency from input beat acceptance to m00_axis_tvalid is 1 cycle.
- Within a frame, with the source and MAC always ready, throughput is one beat per cycle with no bubbles.
- Between frames there is exactly one IDLE cycle: tlast is accepted at cycle t, and the next frame's first beat is accepted no earlier than t+2.
- o_active_channel is registered and updates in the cycle after the grant.
- o_oversize is high for exactly the cycle after the truncating beat is accepted, i.e. coincident with m00_axis_tvalid for the forced-tlast beat.
- s_axis_tready depends combinationally on m00_axis_tready (single register stage, no skid buffer).

## Configuration
- MAC_TX_ARB_STRICT_PRIORITY_EN defined: IDLE grants the lowest-index valid channel, and last_grant is ignored.
- MAC_TX_ARB_STRICT_PRIORITY_EN undefined (default): round-robin as described above.
- Truncation and DRAIN behave identically in both modes.

## Test plan
- **Reset values:** hold i_tx_reset for 3 cycles with all inputs driven -> all outputs 0. Then with all four channels valid, the first grant is o_active_channel=0.
- **Round-robin:** N=4, channels 0 and 2 each continuously offer 3-beat frames -> grant order 0,2,0,2. Each frame is 3 contiguous output beats, with exactly 1 idle cycle between output frames.
- **Truncation:** MAX_BEATS=4, channel 1 sends a 6-beat frame (data 1..6) ->
  - output is beats 1..4 with tlast on beat 4;
  - o_oversize pulses once;
  - beats 5,6 are consumed with tready=1 and not emitted;
  - then IDLE.
- **Exact-length frame:** MAX_BEATS=4, a 4-beat frame with tlast on beat 4 -> no o_oversize, and the frame passes intact.
- **Backpressure:** m00_axis_tready low for 5 cycles mid-frame -> output fields stay stable, s_axis_tready[sel]=0 throughout, and no beat is lost or duplicated (compare with a scoreboard).
- **Strict priority:** build with MAC_TX_ARB_STRICT_PRIORITY_EN, channels 0 and 3 continuously valid -> channel 0 is granted on every arbitration and channel 3 never is.
